// File: rtl/present_pkg.sv
// Shared constants, S-box tables and FSM encoding for the PRESENT-80 decryptor.
package present_pkg;

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned BLK_W  = 64;
  localparam logic [4:0]  ROUNDS = 5'd31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_DECRYPT,
    ST_FINISH
  } state_t;

  // Destination of input bit j under the inverse bit permutation.
  function automatic int unsigned pinv_idx(input int unsigned j);
    return (j == 32'd63) ? 32'd63 : (32'd4 * j) % 32'd63;
  endfunction

endpackage

// File: rtl/present_inv_round.sv
// One inverse PRESENT round plus the matching inverse key-schedule step.
module present_inv_round
  import present_pkg::*;
(
  input  logic [BLK_W-1:0] dreg,
  input  logic [KEY_W-1:0] kreg,
  input  logic [4:0]       rnd,
  output logic [BLK_W-1:0] dreg_next,
  output logic [KEY_W-1:0] kreg_next
);

  logic [BLK_W-1:0] t;
  logic [BLK_W-1:0] p;
  logic [KEY_W-1:0] k;

  always_comb begin
    t = dreg ^ kreg[79:16];
    p = '0;
    for (int unsigned j = 0; j < BLK_W; j++) begin
      p[pinv_idx(j)] = t[j];
    end
    dreg_next = '0;
    for (int unsigned n = 0; n < BLK_W / 4; n++) begin
      dreg_next[4*n +: 4] = SBOX_INV[p[4*n +: 4]];
    end
    // Undo the forward update in reverse order: counter xor, S-box, then rotation.
    k          = kreg;
    k[19:15]   = k[19:15] ^ rnd;
    k[79:76]   = SBOX_INV[k[79:76]];
    kreg_next  = {k[60:0], k[79:61]};
  end

endmodule

// File: rtl/present80_decrypt.sv
// Iterative PRESENT-80 decryptor: forward key expansion to K32, then 31 inverse rounds.
module present80_decrypt
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             iReset_n,
  input  logic             load,
  input  logic [BLK_W-1:0] idat,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] odat,
  output logic             done,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] kreg_q, kreg_d;
  logic [BLK_W-1:0] dreg_q, dreg_d;
  logic [4:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] odat_q, odat_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [KEY_W-1:0] k_fwd;
  logic [BLK_W-1:0] inv_dreg;
  logic [KEY_W-1:0] inv_kreg;

  present_inv_round u_inv_round (
    .dreg      (dreg_q),
    .kreg      (kreg_q),
    .rnd       (rnd_q),
    .dreg_next (inv_dreg),
    .kreg_next (inv_kreg)
  );

  always_comb begin
    k_fwd        = {kreg_q[18:0], kreg_q[79:19]};
    k_fwd[79:76] = SBOX[k_fwd[79:76]];
    k_fwd[19:15] = k_fwd[19:15] ^ rnd_q;
  end

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    dreg_d  = dreg_q;
    rnd_d   = rnd_q;
    odat_d  = odat_q;
    done_d  = 1'b0;
    if (load) begin
      dreg_d  = idat;
      kreg_d  = key;
      rnd_d   = 5'd1;
      odat_d  = '0;
      state_d = ST_KEYEXP;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_KEYEXP: begin
          kreg_d = k_fwd;
          if (rnd_q == ROUNDS) begin
            state_d = ST_DECRYPT;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end
        ST_DECRYPT: begin
          dreg_d = inv_dreg;
          kreg_d = inv_kreg;
          rnd_d  = rnd_q - 5'd1;
          if (rnd_q == 5'd1) state_d = ST_FINISH;
        end
        ST_FINISH: begin
          odat_d  = dreg_q ^ kreg_q[79:16];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      kreg_q  <= '0;
      dreg_q  <= '0;
      rnd_q   <= '0;
      odat_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      dreg_q  <= dreg_d;
      rnd_q   <= rnd_d;
      odat_q  <= odat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign odat = odat_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
